// File: rtl/counter_pkg.sv
// counter_pkg: shared widths and constants for the counter capture slice
package counter_pkg;

    localparam int COUNT_W = 5;
    localparam int WRAP_W  = 3;
    localparam int SNAP_W  = WRAP_W + COUNT_W;
    localparam int DEPTH   = 4;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/counter_capture_fifo.sv
// counter_capture_fifo: generic first-word-fall-through FIFO with occupancy register
module counter_capture_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [Width-1:0]           din,
    input  logic                       pop,
    output logic [Width-1:0]           dout,
    output logic [$clog2(Depth+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(Depth);
    localparam int LW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign full    = level == LW'(Depth);
    assign empty   = level == '0;
    assign dout    = mem[rd_ptr];

    // storage, power-of-2 pointers that wrap on their own, and occupancy count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/counter_capture.sv
// counter_capture: snapshots count plus wrap tally on trigger into a FWFT FIFO
// (wrap tally present only when COUNTER_CAPTURE_WRAP_EN is defined)
module counter_capture
    import counter_pkg::*;
#(
    parameter int Size     = COUNT_W,
    parameter int Depth    = DEPTH,
    parameter int WrapBits = WRAP_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [Size-1:0]             count,
    input  logic                        trigger,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WrapBits+Size-1:0]    out_data,
    output logic [level_w(Depth)-1:0]   level,
    output logic                        full,
    output logic                        empty,
    output logic                        dropped
);

    logic                pop;
    logic                push;
    logic [WrapBits-1:0] tally_next;

    assign out_valid = !empty;
    assign pop       = out_valid & out_ready;
    assign push      = trigger & (!full | pop);

`ifdef COUNTER_CAPTURE_WRAP_EN
    logic [Size-1:0]     prev_count;
    logic [WrapBits-1:0] wrap_tally;
    logic                wrap_now;

    assign wrap_now   = count < prev_count;
    assign tally_next = wrap_tally + WrapBits'(wrap_now);

    // any decrease of count, including a counter reset, bumps the tally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_count <= '0;
            wrap_tally <= '0;
        end else begin
            prev_count <= count;
            wrap_tally <= tally_next;
        end
    end
`else
    assign tally_next = '0;
`endif

    // sticky loss flag: trigger arrived while full with no slot freed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) dropped <= 1'b0;
        else if (trigger & full & !pop) dropped <= 1'b1;
    end

    counter_capture_fifo #(
        .Width(WrapBits + Size),
        .Depth(Depth)
    ) fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .din({tally_next, count}),
        .pop(pop),
        .dout(out_data),
        .level(level),
        .full(full),
        .empty(empty)
    );

endmodule
